// File: rtl/spr_bank_pkg.sv
// spr_bank_pkg: shared constants for the special-purpose register bank.
package spr_bank_pkg;
  localparam int SPR_HI = 0;
  localparam int SPR_LO = 1;
  localparam int SPR_DATA_W = 32;
  localparam logic RST_ENABLE = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic [SPR_DATA_W-1:0] ZERO_WORD = '0;
endpackage

// File: rtl/spr_slot.sv
// spr_slot: one special register with commit mux, forward mux and pending bit.
// Shadow save/restore ports exist only when SPR_SHADOW_EN is defined.
module spr_slot
  import spr_bank_pkg::*;
#(
  parameter int DATA_W = SPR_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SPR_SHADOW_EN
  input  logic              save_i,
  input  logic              restore_i,
`endif
  input  logic              mem_we_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              wb_we_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              lu_issue_i,
  input  logic              lu_we_i,
  input  logic [DATA_W-1:0] lu_data_i,
  input  logic              flush_i,
  input  logic              rd_req_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              pend_o,
  output logic              err_o
);
  logic [DATA_W-1:0] reg_q, reg_d, commit;
  logic              pend_q, pend_d, pend_n;
  logic              err_q, err_d;
`ifdef SPR_SHADOW_EN
  logic [DATA_W-1:0] shadow_q, shadow_d;
`endif
  always_comb begin
    commit = wb_we_i ? wb_data_i : lu_we_i ? lu_data_i : reg_q;
    // a new issue replaces a same-cycle completion, so it keeps the bit set
    pend_n = flush_i ? 1'b0 : lu_issue_i ? 1'b1 : lu_we_i ? 1'b0 : pend_q;
    err_d  = err_q | (lu_issue_i & pend_q & ~lu_we_i);
`ifdef SPR_SHADOW_EN
    reg_d    = restore_i ? shadow_q : commit;
    pend_d   = pend_n & ~restore_i;
    shadow_d = (save_i & ~restore_i) ? commit : shadow_q;
`else
    reg_d  = commit;
    pend_d = pend_n;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      reg_q  <= ZERO_WORD[DATA_W-1:0];
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      reg_q  <= reg_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end
`ifdef SPR_SHADOW_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) shadow_q <= ZERO_WORD[DATA_W-1:0];
    else shadow_q <= shadow_d;
  end
`endif
  assign rdata_o = rst ? '0 :
                   mem_we_i == WRITE_ENABLE ? mem_data_i :
                   wb_we_i  == WRITE_ENABLE ? wb_data_i  :
                   lu_we_i  == WRITE_ENABLE ? lu_data_i  : reg_q;
  assign stall_o = rd_req_i & pend_q & ~lu_we_i;
  assign pend_o  = pend_q;
  assign err_o   = err_q;
endmodule

// File: rtl/spr_bank.sv
// spr_bank: NUM_SPR special registers with MEM/WB/long-latency forwarding and a
// pending scoreboard; SPR_SHADOW_EN adds save_i/restore_i and a shadow copy.
module spr_bank
  import spr_bank_pkg::*;
#(
  parameter int DATA_W  = SPR_DATA_W,
  parameter int NUM_SPR = 2
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef SPR_SHADOW_EN
  input  logic                      save_i,
  input  logic                      restore_i,
`endif
  input  logic [NUM_SPR-1:0]        mem_we_i,
  input  logic [NUM_SPR*DATA_W-1:0] mem_data_i,
  input  logic [NUM_SPR-1:0]        wb_we_i,
  input  logic [NUM_SPR*DATA_W-1:0] wb_data_i,
  input  logic [NUM_SPR-1:0]        lu_issue_i,
  input  logic [NUM_SPR-1:0]        lu_we_i,
  input  logic [NUM_SPR*DATA_W-1:0] lu_data_i,
  input  logic                      flush_i,
  input  logic [NUM_SPR-1:0]        rd_req_i,
  output logic [NUM_SPR*DATA_W-1:0] rdata_o,
  output logic                      stall_req_o,
  output logic [NUM_SPR-1:0]        pend_o,
  output logic                      err_o
);
  logic [NUM_SPR-1:0] stall, err;
  for (genvar i = 0; i < NUM_SPR; i++) begin : g_slot
    spr_slot #(.DATA_W(DATA_W)) u_slot (
      .clk        (clk),
      .rst        (rst),
`ifdef SPR_SHADOW_EN
      .save_i     (save_i),
      .restore_i  (restore_i),
`endif
      .mem_we_i   (mem_we_i[i]),
      .mem_data_i (mem_data_i[i*DATA_W +: DATA_W]),
      .wb_we_i    (wb_we_i[i]),
      .wb_data_i  (wb_data_i[i*DATA_W +: DATA_W]),
      .lu_issue_i (lu_issue_i[i]),
      .lu_we_i    (lu_we_i[i]),
      .lu_data_i  (lu_data_i[i*DATA_W +: DATA_W]),
      .flush_i    (flush_i),
      .rd_req_i   (rd_req_i[i]),
      .rdata_o    (rdata_o[i*DATA_W +: DATA_W]),
      .stall_o    (stall[i]),
      .pend_o     (pend_o[i]),
      .err_o      (err[i])
    );
  end
  assign stall_req_o = |stall;
  assign err_o       = |err;
endmodule

// File: tb/tb_spr_bank.sv
// tb_spr_bank: table-driven directed checks of spr_bank plus reset/shadow sequences.
module tb_spr_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mem_we, wb_we, lu_issue, lu_we, rd_req, pend;
  logic [63:0] mem_data, wb_data, lu_data, rdata;
  logic        flush, stall, err;
`ifdef SPR_SHADOW_EN
  logic        save, restore;
`endif
  int errors = 0;
  int checks = 0;

  spr_bank dut (
    .clk         (clk),
    .rst         (rst),
`ifdef SPR_SHADOW_EN
    .save_i      (save),
    .restore_i   (restore),
`endif
    .mem_we_i    (mem_we),
    .mem_data_i  (mem_data),
    .wb_we_i     (wb_we),
    .wb_data_i   (wb_data),
    .lu_issue_i  (lu_issue),
    .lu_we_i     (lu_we),
    .lu_data_i   (lu_data),
    .flush_i     (flush),
    .rd_req_i    (rd_req),
    .rdata_o     (rdata),
    .stall_req_o (stall),
    .pend_o      (pend),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mem_we;
    logic [63:0] mem_data;
    logic [1:0]  wb_we;
    logic [63:0] wb_data;
    logic [1:0]  lu_issue;
    logic [1:0]  lu_we;
    logic [63:0] lu_data;
    logic        flush;
    logic [1:0]  rd_req;
    logic [63:0] exp_rdata;
    logic        exp_stall;
    logic [1:0]  exp_pend;
    logic        exp_err;
  } vec_t;

  vec_t v[22];

  function automatic vec_t mk(logic [1:0] mw, logic [63:0] md, logic [1:0] ww, logic [63:0] wd,
                              logic [1:0] iss, logic [1:0] lw, logic [63:0] ld, logic fl,
                              logic [1:0] rr, logic [63:0] er, logic es, logic [1:0] ep, logic ee);
    vec_t t;
    t.mem_we = mw; t.mem_data = md; t.wb_we = ww; t.wb_data = wd;
    t.lu_issue = iss; t.lu_we = lw; t.lu_data = ld; t.flush = fl; t.rd_req = rr;
    t.exp_rdata = er; t.exp_stall = es; t.exp_pend = ep; t.exp_err = ee;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    mem_we = t.mem_we; mem_data = t.mem_data; wb_we = t.wb_we; wb_data = t.wb_data;
    lu_issue = t.lu_issue; lu_we = t.lu_we; lu_data = t.lu_data; flush = t.flush; rd_req = t.rd_req;
  endtask

  task automatic idle();
    drive(mk(2'b00, 64'h0, 2'b00, 64'h0, 2'b00, 2'b00, 64'h0, 1'b0, 2'b00, 64'h0, 1'b0, 2'b00, 1'b0));
  endtask

  initial begin
    // data layout is {lo, hi}: slot 0 (HI) occupies the low 32 bits
    v[0]  = mk(2'b00, 64'h0, 2'b01, {32'h0, 32'h1234}, 2'b00, 2'b00, 64'h0, 0, 2'b00, {32'h0, 32'h1234}, 0, 2'b00, 0);
    v[1]  = mk(2'b00, 64'h0, 2'b00, 64'h0, 2'b00, 2'b00, 64'h0, 0, 2'b00, {32'h0, 32'h1234}, 0, 2'b00, 0);
    v[2]  = mk(2'b00, 64'h0, 2'b01, {32'h0, 32'h5}, 2'b00, 2'b00, 64'h0, 0, 2'b00, {32'h0, 32'h5}, 0, 2'b00, 0);
    v[3]  = mk(2'b01, {32'h0, 32'h7}, 2'b01, {32'h0, 32'h9}, 2'b00, 2'b00, 64'h0, 0, 2'b00, {32'h0, 32'h7}, 0, 2'b00, 0);
    v[4]  = mk(2'b00, 64'h0, 2'b00, 64'h0, 2'b00, 2'b00, 64'h0, 0, 2'b00, {32'h0, 32'h9}, 0, 2'b00, 0);
    v[5]  = mk(2'b00, 64'h0, 2'b00, 64'h0, 2'b11, 2'b00, 64'h0, 0, 2'b01, {32'h0, 32'h9}, 0, 2'b11, 0);
    v[6]  = mk(2'b00, 64'h0, 2'b00, 64'h0, 2'b00, 2'b00, 64'h0, 0, 2'b01, {32'h0, 32'h9}, 1, 2'b11, 0);
    v[7]  = v[6];
    v[8]  = v[6];
    v[9]  = mk(2'b00, 64'h0, 2'b00, 64'h0, 2'b00, 2'b11, {32'hB, 32'hA}, 0, 2'b01, {32'hB, 32'hA}, 0, 2'b00, 0);
    v[10] = mk(2'b00, 64'h0, 2'b00, 64'h0, 2'b00, 2'b00, 64'h0, 0, 2'b00, {32'hB, 32'hA}, 0, 2'b00, 0);
    v[11] = mk(2'b00, 64'h0, 2'b00, 64'h0, 2'b01, 2'b00, 64'h0, 0, 2'b00, {32'hB, 32'hA}, 0, 2'b01, 0);
    v[12] = mk(2'b00, 64'h0, 2'b00, 64'h0, 2'b01, 2'b01, {32'h0, 32'hC}, 0, 2'b00, {32'hB, 32'hC}, 0, 2'b01, 0);
    v[13] = mk(2'b00, 64'h0, 2'b00, 64'h0, 2'b01, 2'b00, 64'h0, 0, 2'b00, {32'hB, 32'hC}, 0, 2'b01, 1);
    v[14] = mk(2'b00, 64'h0, 2'b00, 64'h0, 2'b00, 2'b00, 64'h0, 0, 2'b11, {32'hB, 32'hC}, 1, 2'b01, 1);
    v[15] = mk(2'b00, 64'h0, 2'b01, {32'h0, 32'hD}, 2'b00, 2'b01, {32'h0, 32'hE}, 0, 2'b00, {32'hB, 32'hD}, 0, 2'b00, 1);
    v[16] = mk(2'b00, 64'h0, 2'b00, 64'h0, 2'b10, 2'b00, 64'h0, 0, 2'b00, {32'hB, 32'hD}, 0, 2'b10, 1);
    v[17] = mk(2'b00, 64'h0, 2'b00, 64'h0, 2'b01, 2'b00, 64'h0, 0, 2'b10, {32'hB, 32'hD}, 1, 2'b11, 1);
    v[18] = mk(2'b00, 64'h0, 2'b00, 64'h0, 2'b00, 2'b00, 64'h0, 1, 2'b11, {32'hB, 32'hD}, 1, 2'b00, 1);
    v[19] = mk(2'b00, 64'h0, 2'b00, 64'h0, 2'b00, 2'b00, 64'h0, 0, 2'b11, {32'hB, 32'hD}, 0, 2'b00, 1);
    v[20] = mk(2'b00, 64'h0, 2'b00, 64'h0, 2'b00, 2'b10, {32'hF, 32'h0}, 0, 2'b00, {32'hF, 32'hD}, 0, 2'b00, 1);
    v[21] = mk(2'b00, 64'h0, 2'b00, 64'h0, 2'b00, 2'b00, 64'h0, 0, 2'b00, {32'hF, 32'hD}, 0, 2'b00, 1);
`ifdef SPR_SHADOW_EN
    save = 1'b0; restore = 1'b0;
`endif
    rst = 1'b1;
    idle();
    mem_we = 2'b11; mem_data = {32'h11, 32'h22};
    repeat (2) @(posedge clk);
    #2;
    chk("reset_rdata", rdata, 64'h0);
    chk("reset_stall", {63'h0, stall}, 64'h0);
    chk("reset_pend", {62'h0, pend}, 64'h0);
    chk("reset_err", {63'h0, err}, 64'h0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 22; k++) begin
      drive(v[k]);
      #1;
      chk($sformatf("v%0d_rdata", k), rdata, v[k].exp_rdata);
      chk($sformatf("v%0d_stall", k), {63'h0, stall}, {63'h0, v[k].exp_stall});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pend", k), {62'h0, pend}, {62'h0, v[k].exp_pend});
      chk($sformatf("v%0d_err", k), {63'h0, err}, {63'h0, v[k].exp_err});
    end
    // async reset between edges with pending work and active forwarding
    idle();
    lu_issue = 2'b11;
    @(posedge clk);
    #1;
    idle();
    mem_we = 2'b11; mem_data = {32'h1, 32'h2}; rd_req = 2'b11;
    #1;
    chk("pre_rst_stall", {63'h0, stall}, 64'h1);
    chk("pre_rst_rdata", rdata, {32'h1, 32'h2});
    rst = 1'b1;
    #1;
    chk("async_rst_rdata", rdata, 64'h0);
    chk("async_rst_stall", {63'h0, stall}, 64'h0);
    chk("async_rst_pend", {62'h0, pend}, 64'h0);
    chk("async_rst_err", {63'h0, err}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(posedge clk);
    #1;
    chk("post_rst_regs", rdata, 64'h0);
`ifdef SPR_SHADOW_EN
    wb_we = 2'b01; wb_data = {32'h0, 32'h3}; save = 1'b1;
    @(posedge clk);
    #1;
    save = 1'b0; wb_data = {32'h0, 32'h8};
    @(posedge clk);
    #1;
    idle();
    #1;
    chk("shadow_pre_restore", rdata, {32'h0, 32'h8});
    restore = 1'b1; wb_we = 2'b01; wb_data = {32'h0, 32'h6}; lu_issue = 2'b01;
    @(posedge clk);
    #1;
    restore = 1'b0;
    idle();
    #1;
    chk("shadow_restored", rdata, {32'h0, 32'h3});
    chk("shadow_pend_clear", {62'h0, pend}, 64'h0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
